// File: rtl/load_store_unit.sv
// Load/store unit: aligns core byte/half/word accesses onto a word-wide
// data memory, doing read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE, LOAD, READ, WRITE, RESP
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        accept;
  logic        misalign;
  logic        oor;
  logic        err_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  assign misalign = (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign oor      = (req_addr[31:2] >= 30'(MEM_WORDS));
  assign err_in   = misalign || oor || (req_size == 2'b11);

  assign mem_addr = (state == IDLE) ? 32'h0
                                    : {addr_q[31:2], 2'b00};
  assign mem_write_data   = word_q;
  // Reset gates the strobe so an interrupted store never lands.
  assign mem_write_enable = (state == WRITE) && !reset;

  always_comb begin
    lane_b = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_read_data[{addr_q[1], 4'b0000} +: 16];
    ld_val = mem_read_data;
    unique case (size_q)
      2'b00:   ld_val = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   ld_val = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_val = mem_read_data;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = word_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = word_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_error <= 1'b0;
      addr_q     <= 32'h0;
      word_q     <= 32'h0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= req_addr;
            word_q <= req_wdata;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            unique case (1'b1)
              err_in: begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_error <= 1'b1;
                resp_rdata <= 32'h0;
              end
              !err_in && !req_write:
                state <= LOAD;
              !err_in && req_write && req_size == 2'b10:
                state <= WRITE;
              !err_in && req_write && req_size != 2'b10:
                state <= READ;
            endcase
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= ld_val;
          resp_error <= 1'b0;
        end
        READ: begin
          word_q <= merged;
          state  <= WRITE;
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
          resp_error <= 1'b0;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 64, number of 32-bit words in the downstream data memory; word index addr[31:2] >= MEM_WORDS SHALL be out of range.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified for byte/halfword.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 resp_error  output  1  request rejected (misaligned, illegal size, out of range).
REQ-014 mem_addr  output  32  word-aligned address to data memory.
REQ-015 mem_write_data  output  32  full word to write.
REQ-016 mem_write_enable  output  1  write strobe, sampled by memory on clk rising edge.
REQ-017 mem_read_data  input  32  combinational read of mem_addr, valid in the same cycle.

Function
REQ-018 States SHALL be IDLE, LOAD, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted when req_valid && req_ready; all req_* fields are latched at acceptance and ignored thereafter.
REQ-020 Errors: halfword with addr[0]=1, word with addr[1:0]!=00, size 11, or out-of-range index -> IDLE to RESP with resp_error=1; no memory write.
REQ-021 Legal transitions from IDLE: load -> LOAD; word store -> WRITE; byte/halfword store -> READ.
REQ-022 LOAD: capture mem_read_data, select lane, extend into resp_rdata register -> RESP.
REQ-023 READ: capture mem_read_data, replace the addressed byte/halfword lane with req_wdata[7:0]/[15:0] -> WRITE.
REQ-024 WRITE: mem_write_enable=1 for exactly this one cycle with the merged (or full) word -> RESP.
REQ-025 RESP: resp_valid=1 for one cycle -> IDLE; next request is acceptable the following cycle.
REQ-026 Lanes SHALL be little-endian: addr[1:0]=0 selects bits 7:0, 3 selects 31:24; halfword addr[1]=1 selects 31:16.
REQ-027 mem_addr SHALL be {latched addr[31:2],2'b00} outside IDLE and 0 in IDLE; mem_write_enable SHALL be 0 in every state but WRITE.
REQ-028 Latency from acceptance cycle N: error resp at N+1, load and word store at N+2, sub-word store at N+3 with memory write at N+2.
REQ-029 resp_rdata and resp_error SHALL hold their last values between resp_valid pulses.

Reset
REQ-030 With reset=1 at a rising edge: state IDLE, resp_valid 0, resp_rdata 0, resp_error 0, latched request cleared.
REQ-031 reset SHALL take priority over any request or in-flight operation; mem_write_enable SHALL be forced 0 in any cycle reset=1, so an interrupted store never writes.

Verification
REQ-032 Word1=0x0000000A; word load addr 0x4 at N -> resp_valid, resp_rdata=0x0000000A, resp_error=0 at N+2; no write.
REQ-033 Word1=0x80001234; byte load addr 0x7 signed -> 0xFFFFFF80; unsigned -> 0x00000080; halfword addr 0x4 signed -> 0x00001234.
REQ-034 Word2=0x0000000F; byte store 0xAB to addr 0x9 at N -> mem_write_enable=1, mem_addr=0x8, mem_write_data=0x0000AB0F at N+2; resp_valid at N+3.
REQ-035 Word load addr 0x6, and any access addr 0x100 with MEM_WORDS=64 -> resp_error=1, resp_rdata=0 at N+1; mem_write_enable never asserted.
REQ-036 reset=1 during WRITE of a word store -> no memory write, memory word unchanged, all outputs at reset values, req_ready=1 next cycle.
REQ-037 req_valid held high for two stores -> req_ready=0 during LOAD/READ/WRITE/RESP; second accepted the cycle after first resp_valid; both writes land.
